led_frame_scheduler: RTL and testbench

- Sequences one full refresh of the 8x8 WS2812B matrix: steps the pixel address, issues memory read and shift-register load strobes, and gates the serial driver's transmit window with per-bit shift pulses.
- Inserts the WS2812B latch (reset) gap after the last pixel, then paces frames to a fixed period.
- Rotates the active colour channel (G, R, B) once per frame.
- Sits between the pattern memory / 24-bit shift register and the ws2812b driver.

---
 rtl/led_frame_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_led_frame_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler
// Sequences one refresh of a WS2812B pixel chain. For each pixel it issues
// a memory read, a shift-register load and a transmit window with per-bit
// shift pulses. After the last pixel it holds the latch gap, rotates the
// colour channel, and then paces the next frame to a fixed period.
module led_frame_scheduler #(
    parameter int NUM_PIXELS     = 64,
    parameter int BIT_CYCLES     = 15,
    parameter int BITS_PER_PIXEL = 24,
    parameter int LATCH_CYCLES   = 1000,
    parameter int FRAME_CYCLES   = 200000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    output logic [$clog2(NUM_PIXELS)-1:0] pixel,
    output logic                          rd_en,
    output logic                          load_sreg,
    output logic                          transmit_pixel,
    output logic                          shift,
    output logic                          newframe,
    output logic [1:0]                    channel,
    output logic                          busy,
    output logic                          overrun
);

    localparam int PIX_W = $clog2(NUM_PIXELS);
    localparam int BIT_W = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;
    localparam int CYC_W = (BIT_CYCLES > 1)     ? $clog2(BIT_CYCLES)     : 1;
    localparam int LAT_W = (LATCH_CYCLES > 1)   ? $clog2(LATCH_CYCLES)   : 1;
    localparam int TMR_W = (FRAME_CYCLES > 1)   ? $clog2(FRAME_CYCLES)   : 1;

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIXELS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_PIXEL - 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FRAME_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_SEND  = 3'd3,
        S_LATCH = 3'd4,
        S_WAIT  = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PIX_W-1:0]   r_pixel;
    logic [BIT_W-1:0]   r_bit;
    logic [CYC_W-1:0]   r_cyc;
    logic [LAT_W-1:0]   r_lat;
    logic [TMR_W-1:0]   r_timer;
    logic [1:0]         r_channel;
    logic               r_newframe;

    logic w_send_last;
    logic w_latch_last;
    logic w_pixel_last;
    logic w_timer_done;
    logic w_start_frame;

    assign w_send_last  = (r_state == S_SEND) && (r_bit == BIT_LAST) && (r_cyc == CYC_LAST);
    assign w_latch_last = (r_state == S_LATCH) && (r_lat == LAT_LAST);
    assign w_pixel_last = (r_pixel == PIX_LAST);
    assign w_timer_done = (r_timer == TMR_LAST);
    // A FETCH entered from anywhere but SEND is the first pixel of a new frame.
    assign w_start_frame = (w_state_nxt == S_FETCH) && (r_state != S_SEND);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) w_state_nxt = S_FETCH;
                else        w_state_nxt = S_IDLE;
            end
            S_FETCH: w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SEND;
            S_SEND: begin
                if (w_send_last) begin
                    if (w_pixel_last) w_state_nxt = S_LATCH;
                    else              w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_SEND;
                end
            end
            S_LATCH: begin
                if (!w_latch_last)     w_state_nxt = S_LATCH;
                else if (!enable)      w_state_nxt = S_IDLE;
                else if (w_timer_done) w_state_nxt = S_FETCH;
                else                   w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!enable)           w_state_nxt = S_IDLE;
                else if (w_timer_done) w_state_nxt = S_FETCH;
                else                   w_state_nxt = S_WAIT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pixel address, bit/cycle/latch counters, frame timer and channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pixel    <= PIX_W'(0);
            r_bit      <= BIT_W'(0);
            r_cyc      <= CYC_W'(0);
            r_lat      <= LAT_W'(0);
            r_timer    <= TMR_W'(0);
            r_channel  <= 2'd0;
            r_newframe <= 1'b0;
        end else begin
            r_newframe <= w_start_frame;

            if (w_send_last && !w_pixel_last) r_pixel <= r_pixel + PIX_W'(1);
            else if (w_latch_last)            r_pixel <= PIX_W'(0);
            else                              r_pixel <= r_pixel;

            if (r_state == S_SEND) begin
                if (r_cyc == CYC_LAST) begin
                    r_cyc <= CYC_W'(0);
                    if (r_bit == BIT_LAST) r_bit <= BIT_W'(0);
                    else                   r_bit <= r_bit + BIT_W'(1);
                end else begin
                    r_cyc <= r_cyc + CYC_W'(1);
                    r_bit <= r_bit;
                end
            end else begin
                r_cyc <= CYC_W'(0);
                r_bit <= BIT_W'(0);
            end

            if (r_state == S_LATCH && !w_latch_last) r_lat <= r_lat + LAT_W'(1);
            else                                     r_lat <= LAT_W'(0);

            // Timer restarts on each newframe and saturates one short of the period.
            if (w_start_frame)      r_timer <= TMR_W'(0);
            else if (!w_timer_done) r_timer <= r_timer + TMR_W'(1);
            else                    r_timer <= r_timer;

            if (w_latch_last) begin
                if (r_channel == 2'd2) r_channel <= 2'd0;
                else                   r_channel <= r_channel + 2'd1;
            end else begin
                r_channel <= r_channel;
            end
        end
    end

    // Output decode from the current state; overrun follows enable at LATCH exit.
    always_comb begin
        rd_en          = 1'b0;
        load_sreg      = 1'b0;
        transmit_pixel = 1'b0;
        shift          = 1'b0;
        busy           = 1'b1;
        overrun        = 1'b0;
        case (r_state)
            S_IDLE:  busy = 1'b0;
            S_FETCH: rd_en = 1'b1;
            S_LOAD:  load_sreg = 1'b1;
            S_SEND: begin
                transmit_pixel = 1'b1;
                // No shift after the final bit: the next load replaces the register.
                if ((r_cyc == CYC_LAST) && (r_bit != BIT_LAST)) shift = 1'b1;
                else                                            shift = 1'b0;
            end
            S_LATCH: overrun = w_latch_last & enable & w_timer_done;
            S_WAIT:  busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign pixel    = r_pixel;
    assign channel  = r_channel;
    assign newframe = r_newframe;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Bench for led_frame_scheduler: a small geometry instance at two frame
// periods (one with slack, one that always overruns), a hand-derived vector
// table for one frame, directed corner sequences, and a random phase
// checked every cycle against a frame-offset reference model.
module tb_led_frame_scheduler;

    localparam int NP  = 4;
    localparam int BC  = 2;
    localparam int BPP = 24;
    localparam int LC  = 10;
    localparam int PL  = 2 + BPP * BC;   // cycles per pixel slot
    localparam int FL  = NP * PL + LC;   // frame content length

    int frame_len [2] = '{300, 150};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;

    always #5 clk = ~clk;

    logic [1:0] a_pixel, b_pixel, a_channel, b_channel;
    logic a_rd_en, a_load, a_tx, a_shift, a_nf, a_busy, a_ov;
    logic b_rd_en, b_load, b_tx, b_shift, b_nf, b_busy, b_ov;

    led_frame_scheduler #(.NUM_PIXELS(NP), .BIT_CYCLES(BC), .BITS_PER_PIXEL(BPP),
                          .LATCH_CYCLES(LC), .FRAME_CYCLES(300)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en), .pixel(a_pixel), .rd_en(a_rd_en),
        .load_sreg(a_load), .transmit_pixel(a_tx), .shift(a_shift), .newframe(a_nf),
        .channel(a_channel), .busy(a_busy), .overrun(a_ov));

    led_frame_scheduler #(.NUM_PIXELS(NP), .BIT_CYCLES(BC), .BITS_PER_PIXEL(BPP),
                          .LATCH_CYCLES(LC), .FRAME_CYCLES(150)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en), .pixel(b_pixel), .rd_en(b_rd_en),
        .load_sreg(b_load), .transmit_pixel(b_tx), .shift(b_shift), .newframe(b_nf),
        .channel(b_channel), .busy(b_busy), .overrun(b_ov));

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: running flag, cycle offset since newframe, channel.
    bit m_run [2];
    int m_k   [2];
    int m_ch  [2];

    typedef struct {
        int   k;
        logic nf;
        logic rd;
        logic ld;
        logic tx;
        logic sh;
        logic bz;
        int   px;
        int   ch;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int tmr_of(int i, int k);
        return (k < frame_len[i] - 1) ? k : frame_len[i] - 1;
    endfunction

    task automatic model_step(input int i);
        if (!rst_n) begin
            m_run[i] = 1'b0;
            m_k[i]   = 0;
            m_ch[i]  = 0;
        end else if (!m_run[i]) begin
            if (en) begin
                m_run[i] = 1'b1;
                m_k[i]   = 0;
            end
        end else if (m_k[i] < FL - 1) begin
            m_k[i]++;
        end else begin
            if (m_k[i] == FL - 1) m_ch[i] = (m_ch[i] + 1) % 3;
            if (!en)                                          m_run[i] = 1'b0;
            else if (tmr_of(i, m_k[i]) == frame_len[i] - 1)   m_k[i] = 0;
            else                                              m_k[i]++;
        end
    endtask

    // {newframe, rd_en, load, transmit, shift, busy, overrun, channel, pixel}
    function automatic logic [10:0] exp_vec(int i);
        logic nf, rd, ld, tx, sh, bz, ov;
        int px, k, off, s;
        nf = 1'b0; rd = 1'b0; ld = 1'b0; tx = 1'b0; sh = 1'b0; bz = 1'b0; ov = 1'b0;
        px = 0;
        k  = m_k[i];
        if (m_run[i]) begin
            bz = 1'b1;
            nf = (k == 0);
            if (k < NP * PL) begin
                px  = k / PL;
                off = k % PL;
                rd  = (off == 0);
                ld  = (off == 1);
                tx  = (off >= 2);
                s   = off - 2;
                sh  = tx && (s % BC == BC - 1) && (s / BC < BPP - 1);
            end else if (k < FL) begin
                px = NP - 1;
                ov = (k == FL - 1) && en && (tmr_of(i, k) == frame_len[i] - 1);
            end
        end
        return {nf, rd, ld, tx, sh, bz, ov, 2'(m_ch[i]), 2'(px)};
    endfunction

    function automatic logic [10:0] act_vec(int i);
        if (i == 0) return {a_nf, a_rd_en, a_load, a_tx, a_shift, a_busy, a_ov, a_channel, a_pixel};
        else        return {b_nf, b_rd_en, b_load, b_tx, b_shift, b_busy, b_ov, b_channel, b_pixel};
    endfunction

    // One clock: model follows the edge, new inputs applied, outputs compared.
    task automatic tick(input logic en_nxt, input logic rst_nxt);
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) model_step(i);
        #1;
        en    = en_nxt;
        rst_n = rst_nxt;
        #1;
        chk("model_a", 32'(act_vec(0)), 32'(exp_vec(0)));
        chk("model_b", 32'(act_vec(1)), 32'(exp_vec(1)));
    endtask

    initial begin
        int ti, n_rd, n_ld, n_tx, n_sh, n_both, n_bad_rd, n_bad_gap, last_sh, last_px;
        int last_a, last_b, exp_ch, n_ov_a, n_ov_b, n_nf, n_bz;
        logic prev_rd, prev_ov_b, found, en_r, rst_r;

        tbl[0]  = '{0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0};
        tbl[1]  = '{1,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0};
        tbl[2]  = '{2,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0};
        tbl[3]  = '{3,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0};
        tbl[4]  = '{4,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0};
        tbl[5]  = '{47,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0};
        tbl[6]  = '{49,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0};
        tbl[7]  = '{50,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0};
        tbl[8]  = '{51,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0};
        tbl[9]  = '{150, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3, 0};
        tbl[10] = '{199, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3, 0};
        tbl[11] = '{200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 0};
        tbl[12] = '{209, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 0};
        tbl[13] = '{210, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1};
        tbl[14] = '{300, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1};

        for (int i = 0; i < 2; i++) begin
            m_run[i] = 1'b0;
            m_k[i]   = 0;
            m_ch[i]  = 0;
        end

        // Reset, then idle with enable low.
        repeat (3) tick(1'b0, 1'b0);
        repeat (20) tick(1'b0, 1'b1);
        chk("idle_busy", 32'(a_busy), 32'(0));
        chk("idle_outputs", 32'({a_rd_en, a_load, a_tx, a_shift, a_nf, a_ov, a_channel, a_pixel}), 32'(0));

        // One frame against the hand-derived table.
        tick(1'b1, 1'b1);
        ti = 0; n_rd = 0; n_ld = 0; n_tx = 0; n_sh = 0; n_both = 0; n_bad_rd = 0; n_bad_gap = 0;
        last_sh = -10; last_px = -1; prev_rd = 1'b0;
        for (int c = 0; c <= 300; c++) begin
            tick(1'b1, 1'b1);
            if (c < FL) begin
                n_rd += int'(a_rd_en);
                n_ld += int'(a_load);
                n_tx += int'(a_tx);
                n_sh += int'(a_shift);
                if (a_load && a_shift) n_both++;
                if (a_load && !prev_rd) n_bad_rd++;
                if (a_shift) begin
                    if (last_px == int'(a_pixel) && c - last_sh != 2) n_bad_gap++;
                    last_sh = c;
                    last_px = int'(a_pixel);
                end
            end
            prev_rd = a_rd_en;
            if (ti < 15 && tbl[ti].k == c) begin
                chk($sformatf("tbl_k%0d", tbl[ti].k),
                    32'({a_nf, a_rd_en, a_load, a_tx, a_shift, a_busy, a_pixel, a_channel}),
                    32'({tbl[ti].nf, tbl[ti].rd, tbl[ti].ld, tbl[ti].tx, tbl[ti].sh, tbl[ti].bz,
                         2'(tbl[ti].px), 2'(tbl[ti].ch)}));
                ti++;
            end
        end
        chk("frame_rd_en", 32'(n_rd), 32'(NP));
        chk("frame_load", 32'(n_ld), 32'(NP));
        chk("frame_tx", 32'(n_tx), 32'(NP * BPP * BC));
        chk("frame_shift", 32'(n_sh), 32'(NP * (BPP - 1)));
        chk("load_shift_overlap", 32'(n_both), 32'(0));
        chk("rd_before_load", 32'(n_bad_rd), 32'(0));
        chk("shift_spacing", 32'(n_bad_gap), 32'(0));

        // Free-running: period 300 without overrun; period 210 with overrun.
        last_a = cyc; last_b = -1; exp_ch = 2; n_ov_a = 0; n_ov_b = 0; prev_ov_b = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            tick(1'b1, 1'b1);
            n_ov_a += int'(a_ov);
            n_ov_b += int'(b_ov);
            if (a_nf) begin
                chk("period_a", 32'(cyc - last_a), 32'(300));
                chk("chan_a", 32'(a_channel), 32'(exp_ch));
                exp_ch = (exp_ch + 1) % 3;
                last_a = cyc;
            end
            if (b_nf) begin
                chk("nf_after_ov_b", 32'(prev_ov_b), 32'(1));
                if (last_b >= 0) chk("period_b", 32'(cyc - last_b), 32'(FL));
                last_b = cyc;
            end
            prev_ov_b = b_ov;
        end
        chk("overrun_a_never", 32'(n_ov_a), 32'(0));
        chk("overrun_b_seen", 32'(n_ov_b >= 4), 32'(1));

        // Drop enable during pixel 1: frame completes, then IDLE.
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            tick(1'b1, 1'b1);
            if (m_run[0] && m_k[0] == 60) found = 1'b1;
        end
        chk("reach_pixel1", 32'(found), 32'(1));
        n_nf = 0; n_rd = 0; n_bz = 0;
        for (int c = 0; c < 250; c++) begin
            tick(1'b0, 1'b1);
            n_nf += int'(a_nf);
            n_rd += int'(a_rd_en);
            n_bz += int'(a_busy);
        end
        chk("drop_newframe", 32'(n_nf), 32'(0));
        chk("drop_rd_en", 32'(n_rd), 32'(2));
        chk("drop_busy_cycles", 32'(n_bz), 32'(FL - 61));
        chk("drop_idle", 32'({a_busy, a_pixel}), 32'(0));

        // Reset for one cycle mid-SEND of pixel 2.
        tick(1'b1, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            tick(1'b1, 1'b1);
            if (m_run[0] && m_k[0] == 110) found = 1'b1;
        end
        chk("reach_pixel2", 32'(found), 32'(1));
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        chk("rst_tx", 32'(a_tx), 32'(0));
        chk("rst_pixel", 32'(a_pixel), 32'(0));
        chk("rst_channel", 32'(a_channel), 32'(0));
        chk("rst_busy", 32'(a_busy), 32'(0));
        n_sh = 0;
        for (int c = 0; c < 10; c++) begin
            tick(1'b0, 1'b1);
            n_sh += int'(a_shift) + int'(a_rd_en) + int'(a_load);
        end
        chk("rst_no_strobes", 32'(n_sh), 32'(0));

        // Random enable toggling and occasional resets against the model.
        en_r = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 149) == 0) en_r = ~en_r;
            rst_r = ($urandom_range(0, 1999) != 0);
            tick(en_r, rst_r);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
